// File: rtl/act_pkg.sv
// Shared constants and mode encoding for the activation output stage.
// The constants use the binary32 layout.
package act_pkg;

   localparam logic [31:0] ONE  = 32'h3F80_0000;
   localparam logic [31:0] HALF = 32'h3F00_0000;
   localparam logic [31:0] ZERO = 32'h0000_0000;
   localparam logic [31:0] QNAN = 32'h7FC0_0000;

   typedef enum logic {
      MODE_SIGMOID = 1'b0,
      MODE_TANH    = 1'b1
   } act_mode_e;

endpackage

// File: rtl/floating_point_adder.sv
// Combinational IEEE-754 adder with round-to-nearest-even and subnormal
// support. NaN operands, or infinities of opposite sign, give a quiet NaN.
// Callers subtract by flipping the sign bit of in2.
module floating_point_adder #(
   parameter int DATA_WIDTH = 32,
   parameter int M          = 23,
   parameter int E          = 8
) (
   input  logic [DATA_WIDTH-1:0] in1,
   input  logic [DATA_WIDTH-1:0] in2,
   output logic [DATA_WIDTH-1:0] out
);

   // Working width: hidden bit, fraction, guard/round/sticky.
   localparam int W = M + 4;
   localparam logic [E-1:0]          EXP_ONES = '1;
   localparam logic [DATA_WIDTH-1:0] QNAN_W   = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};

   logic                  a_nan, b_nan, a_inf, b_inf, swap, round_up;
   logic [DATA_WIDTH-1:0] big, sml;
   logic [E-1:0]          eb_raw, es_raw, exp_fld;
   logic [W-1:0]          ml, ms, ms_sh, nm;
   logic [W:0]            sum;
   logic [M+1:0]          mr;
   logic [M-1:0]          frac;
   int                    el, es, d, lz, sh, ex, ex_fin;

   // Align, add/subtract magnitudes, normalise, round.
   always_comb begin
      a_nan  = (in1[DATA_WIDTH-2 -: E] == EXP_ONES) && (in1[M-1:0] != '0);
      b_nan  = (in2[DATA_WIDTH-2 -: E] == EXP_ONES) && (in2[M-1:0] != '0);
      a_inf  = (in1[DATA_WIDTH-2 -: E] == EXP_ONES) && (in1[M-1:0] == '0);
      b_inf  = (in2[DATA_WIDTH-2 -: E] == EXP_ONES) && (in2[M-1:0] == '0);

      // Larger magnitude goes first so the subtraction never goes negative.
      swap   = in2[DATA_WIDTH-2:0] > in1[DATA_WIDTH-2:0];
      big    = swap ? in2 : in1;
      sml    = swap ? in1 : in2;
      eb_raw = big[DATA_WIDTH-2 -: E];
      es_raw = sml[DATA_WIDTH-2 -: E];
      el     = (eb_raw == '0) ? 1 : int'(eb_raw);
      es     = (es_raw == '0) ? 1 : int'(es_raw);
      ml     = {eb_raw != '0, big[M-1:0], 3'b000};
      ms     = {es_raw != '0, sml[M-1:0], 3'b000};

      // Shift the smaller operand right; any bit lost folds into sticky.
      d      = el - es;
      ms_sh  = ms >> d;
      if ((ms_sh << d) != ms) ms_sh[0] = 1'b1;

      if (big[DATA_WIDTH-1] == sml[DATA_WIDTH-1]) sum = {1'b0, ml} + {1'b0, ms_sh};
      else                                        sum = {1'b0, ml} - {1'b0, ms_sh};

      lz = W;
      for (int i = 0; i < W; i++) if (sum[i]) lz = W - 1 - i;

      // Carry-out shifts right; otherwise shift left but stop at the
      // subnormal boundary (exponent 1).
      sh = 0;
      if (sum[W]) begin
         nm    = sum[W:1];
         nm[0] = sum[1] | sum[0];
         ex    = el + 1;
      end else begin
         sh = (lz < el - 1) ? lz : el - 1;
         nm = sum[W-1:0] << sh;
         ex = el - sh;
      end

      round_up = nm[2] & (nm[1] | nm[0] | nm[3]);
      mr       = {1'b0, nm[W-1:3]} + {{(M+1){1'b0}}, round_up};
      if (mr[M+1]) begin
         ex_fin = ex + 1;
         frac   = mr[M:1];
      end else if (mr[M]) begin
         ex_fin = ex;
         frac   = mr[M-1:0];
      end else begin
         ex_fin = 0;
         frac   = mr[M-1:0];
      end
      exp_fld = E'(ex_fin);

      if (a_nan | b_nan | (a_inf & b_inf & (in1[DATA_WIDTH-1] != in2[DATA_WIDTH-1])))
         out = QNAN_W;
      else if (a_inf)
         out = in1;
      else if (b_inf)
         out = in2;
      else if (sum == '0)
         out = '0;
      else if (ex_fin >= int'(EXP_ONES))
         out = {big[DATA_WIDTH-1], EXP_ONES, {M{1'b0}}};
      else
         out = {big[DATA_WIDTH-1], exp_fld, frac};
   end

endmodule

// File: rtl/floating_point_activation_output_stage.sv
// Final stage of the sigmoid/tanh unit. It turns the positive-half result
// s_pos into the signed activation value:
//   sigmoid: s_pos, or 1 - s_pos for negative x
//   tanh   : +/-(2*s_pos - 1), magnitude clamped to 1.0
// This is a 3-deep pipeline (capture, adder, output) with a single global
// advance/hold.
// Optional: define ACT_OUT_SAT_CNT_EN to add the sat_cnt output, which counts
// delivered +/-1.0 results.
module floating_point_activation_output_stage
   import act_pkg::*;
#(
   parameter int DATA_WIDTH = 32,
   parameter int M          = 23,
   parameter int E          = 8
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  in_valid,
   output logic                  in_ready,
   input  logic [DATA_WIDTH-1:0] s_pos,
   input  logic                  in_sign,
   input  logic                  mode,
   output logic                  out_valid,
   input  logic                  out_ready,
   output logic [DATA_WIDTH-1:0] out_data
`ifdef ACT_OUT_SAT_CNT_EN
   ,
   output logic [15:0]           sat_cnt
`endif
);

   localparam logic [E-1:0]          EXP_ONES = '1;
   localparam logic [E-1:0]          EXP_MAXN = EXP_ONES - 1'b1;
   localparam logic [E-1:0]          EXP_BIAS = {1'b0, {(E-1){1'b1}}};
   localparam logic [DATA_WIDTH-1:0] ONE_W    = {1'b0, EXP_BIAS, {M{1'b0}}};
   localparam logic [DATA_WIDTH-1:0] QNAN_W   = {1'b0, EXP_ONES, 1'b1, {(M-1){1'b0}}};

   logic                  advance;
   logic [2:0]            vld_q;

   logic [DATA_WIDTH-1:0] s1_spos_q;
   logic                  s1_sign_q;
   act_mode_e             s1_mode_q;
   logic [E-1:0]          s1_exp;
   logic                  s1_nan, s1_ovf;
   logic [DATA_WIDTH-1:0] s1_dbl, add_in1, add_in2, add_out;

   logic [DATA_WIDTH-1:0] s2_sum_q, s2_pass_q, s2_mag;
   logic                  s2_sign_q, s2_nan_q, s2_ovf_q;
   act_mode_e             s2_mode_q;

   logic [DATA_WIDTH-1:0] out_data_d, out_data_q;

   // The pipeline moves only when the output register is free or draining.
   assign advance   = out_ready | ~vld_q[2];
   assign in_ready  = advance;
   assign out_valid = vld_q[2];
   assign out_data  = out_data_q;

   // Per-stage valid bits shift together on advance
   always_ff @(posedge clk) begin
      if (!rst_n)       vld_q <= '0;
      else if (advance) vld_q <= {vld_q[1:0], in_valid};
   end

   // S1: capture the incoming word
   always_ff @(posedge clk) begin
      if (advance) begin
         s1_spos_q <= s_pos;
         s1_sign_q <= in_sign;
         s1_mode_q <= act_mode_e'(mode);
      end
   end

   // Build adder operands; tanh doubles s_pos by bumping its exponent
   always_comb begin
      s1_exp = s1_spos_q[DATA_WIDTH-2 -: E];
      s1_nan = (s1_exp == EXP_ONES);
      // Doubling the largest finite binade overflows; the result clamps later.
      s1_ovf = (s1_exp == EXP_MAXN);
      if (s1_exp == '0)
         s1_dbl = {s1_spos_q[DATA_WIDTH-1], s1_spos_q[DATA_WIDTH-3:0], 1'b0};
      else
         s1_dbl = {s1_spos_q[DATA_WIDTH-1], s1_exp + 1'b1, s1_spos_q[M-1:0]};

      if (s1_mode_q == MODE_TANH) begin
         add_in1 = s1_dbl;
         add_in2 = {1'b1, ONE_W[DATA_WIDTH-2:0]};
      end else begin
         add_in1 = ONE_W;
         add_in2 = {~s1_spos_q[DATA_WIDTH-1], s1_spos_q[DATA_WIDTH-2:0]};
      end
   end

   floating_point_adder #(
      .DATA_WIDTH (DATA_WIDTH),
      .M          (M),
      .E          (E)
   ) u_add (
      .in1 (add_in1),
      .in2 (add_in2),
      .out (add_out)
   );

   // S2: register the difference plus the flags the output stage needs
   always_ff @(posedge clk) begin
      if (advance) begin
         s2_sum_q  <= add_out;
         s2_pass_q <= s1_spos_q;
         s2_sign_q <= s1_sign_q;
         s2_mode_q <= s1_mode_q;
         s2_nan_q  <= s1_nan;
         s2_ovf_q  <= s1_ovf;
      end
   end

   // Apply the sign, the special cases and the tanh clamp
   always_comb begin
      s2_mag = {1'b0, s2_sum_q[DATA_WIDTH-2:0]};
      if (s2_nan_q)
         out_data_d = QNAN_W;
      else if (s2_mode_q == MODE_TANH) begin
         if (s2_ovf_q || (s2_mag > ONE_W))
            out_data_d = {s2_sign_q, ONE_W[DATA_WIDTH-2:0]};
         else if (s2_mag == '0)
            out_data_d = '0;
         else
            out_data_d = {s2_sign_q, s2_mag[DATA_WIDTH-2:0]};
      end else if (!s2_sign_q)
         out_data_d = s2_pass_q;
      else if (s2_mag == '0)
         out_data_d = '0;
      else
         out_data_d = s2_sum_q;
   end

   // S3: output register; holds under stall
   always_ff @(posedge clk) begin
      if (!rst_n)                  out_data_q <= '0;
      else if (advance && vld_q[1]) out_data_q <= out_data_d;
   end

`ifdef ACT_OUT_SAT_CNT_EN
   logic [15:0] sat_cnt_q;

   // Count delivered +/-1.0 results, sticking at full scale
   always_ff @(posedge clk) begin
      if (!rst_n)
         sat_cnt_q <= '0;
      else if (vld_q[2] && out_ready &&
               (out_data_q[DATA_WIDTH-2:0] == ONE_W[DATA_WIDTH-2:0]) &&
               (sat_cnt_q != 16'hFFFF))
         sat_cnt_q <= sat_cnt_q + 16'd1;
   end

   assign sat_cnt = sat_cnt_q;
`endif

endmodule

// File: doc/floating_point_activation_output_stage.md
FLOATING_POINT_ACTIVATION_OUTPUT_STAGE -- requirements
Module: floating_point_activation_output_stage

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 32, total IEEE-754 word width.
REQ-002 SHALL have parameter M, default 23, mantissa width.
REQ-003 SHALL have parameter E, default 8, exponent width.
REQ-004 SHALL have port clk, input, 1, single clock; all state updates on its rising edge.
REQ-005 SHALL have port rst_n, input, 1, reset, synchronous and active-low.
REQ-006 SHALL have port in_valid, input, 1, upstream word valid.
REQ-007 SHALL have port in_ready, output, 1, stage accepts a word this cycle.
REQ-008 SHALL have port s_pos, input, DATA_WIDTH, positive-half sigmoid result: sigmoid(|x|), or sigmoid(2|x|) in tanh mode.
REQ-009 SHALL have port in_sign, input, 1, sign bit of the original x.
REQ-010 SHALL have port mode, input, 1, 0 = sigmoid, 1 = tanh; sampled with the word.
REQ-011 SHALL have port out_valid, output, 1, result valid.
REQ-012 SHALL have port out_ready, input, 1, downstream accepts.
REQ-013 SHALL have port out_data, output, DATA_WIDTH, final activation value.

Function
REQ-014 Sigmoid mode SHALL output s_pos when in_sign=0 and 1.0 - s_pos when in_sign=1.
REQ-015 Tanh mode SHALL form 2*s_pos by exponent increment, then output (2*s_pos - 1.0) with sign bit = in_sign.
REQ-016 Subtraction SHALL use one floating_point_adder, with the in2 sign bit flipped for subtraction.
REQ-017 Pipeline SHALL be 3 stages: S1 input capture, S2 adder result register, S3 sign/special-case output register; latency 3 cycles from accept to out_valid with no stall.
REQ-018 A word SHALL transfer in when in_valid and in_ready are both 1; it SHALL transfer out when out_valid and out_ready are both 1.
REQ-019 advance = out_ready OR NOT out_valid; in_ready SHALL equal advance; all stages SHALL hold when advance=0; per-stage valid bits SHALL shift on advance.
REQ-020 Under stall, out_data and out_valid SHALL stay stable until accepted; no word SHALL be lost or duplicated.
REQ-021 The stage SHALL sustain 1 word/cycle when out_ready=1.
REQ-022 Sigmoid, in_sign=1, s_pos exactly 1.0 (0x3F800000) SHALL output +0 (0x00000000).
REQ-023 Tanh, s_pos exactly 0.5 SHALL output +0 regardless of in_sign.
REQ-024 An s_pos with exponent all ones SHALL output canonical NaN 0x7FC00000.
REQ-025 Tanh results with magnitude above 1.0 SHALL clamp to ±1.0.

Reset
REQ-026 While rst_n=0 at a clock edge, all stage valid bits SHALL clear, out_valid=0, out_data=0, and in_ready=1.
REQ-027 Reset mid-operation SHALL discard in-flight words; the first accept after release SHALL produce out_valid 3 cycles later.

Configuration
REQ-028 With ACT_OUT_SAT_CNT_EN defined: output port sat_cnt[15:0] SHALL count output transfers whose value is ±1.0, saturate at 0xFFFF, and reset to 0.
REQ-029 Without ACT_OUT_SAT_CNT_EN: no sat_cnt port and no counter logic.

Structure
REQ-030 A shared package act_pkg SHALL hold the 32-bit constants ONE (0x3F800000), HALF, ZERO, and QNAN (0x7FC00000), plus the mode encoding.
REQ-031 The only sub-module SHALL be the existing floating_point_adder; no new sub-module.

Verification
REQ-032 Sigmoid: s_pos=0x3F400000 (0.75), in_sign=1 -> out_data=0x3E800000 (0.25) 3 cycles after accept.
REQ-033 Tanh: s_pos=0x3F600000 (0.875), in_sign=1 -> out_data=0xBF400000 (-0.75); with in_sign=0 -> 0x3F400000.
REQ-034 Boundaries: sigmoid s_pos=0x3F800000, in_sign=1 -> 0x00000000; tanh s_pos=0x3F000000, in_sign=1 -> 0x00000000; s_pos=0x7F800001 -> 0x7FC00000.
REQ-035 Backpressure: stream 5 words while out_ready=0 for 6 cycles -> in_ready drops after 3 accepts; all 5 words emerge in order with held data stable.
REQ-036 Reset: assert rst_n=0 with 3 words in flight -> out_valid=0 next cycle; no stale word appears after release.
REQ-037 With ACT_OUT_SAT_CNT_EN: 4 outputs equal to 0x3F800000 or 0xBF800000 -> sat_cnt=4.
